// File: rtl/mmio_peripheral_pkg.sv
// Shared constants and types for the MMIO peripheral block: register offsets,
// TCON bit positions and the timer state encoding.
package mmio_peripheral_pkg;

  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_LED     = 3'd3;
  localparam logic [2:0] OFF_DIGI    = 3'd4;
  localparam logic [2:0] OFF_SYSTICK = 3'd5;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  localparam logic [11:0] DIGI_RESET = 12'hFFF;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/mmio_peripheral_if.sv
// MEM-stage load/store bus as seen by the peripheral; the pipeline is the
// master, the peripheral is the slave.
interface mmio_peripheral_if;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;
  logic        hit;

  modport master (output Address, Write_data, MemRead, MemWrite,
                  input  Read_data, hit);
  modport slave  (input  Address, Write_data, MemRead, MemWrite,
                  output Read_data, hit);
endinterface

// File: rtl/mmio_timer.sv
// Reloadable timer: TH/TL/TCON registers, prescaler, overflow reload and the
// interrupt request derived from TCON.
module mmio_timer
  import mmio_peripheral_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_th,
  input  logic        wr_tl,
  input  logic        wr_tcon,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  logic [15:0]  pre_r;
  logic [31:0]  th_r;
  logic [31:0]  tl_r;
  logic [2:0]   tcon_r;
  timer_state_e state_s;
  logic         tick_s;
  logic         ovf_s;

  assign state_s = timer_state_e'(tcon_r[TCON_EN]);
  assign ovf_s   = tick_s && (tl_r == 32'hFFFF_FFFF);

  // Tick generation: a TL step happens when the prescaler reaches its last count.
  always_comb begin
    tick_s = 1'b0;
    case (state_s)
      T_RUN:   tick_s = (pre_r == 16'(PRESCALE - 1));
      T_IDLE:  tick_s = 1'b0;
      default: tick_s = 1'b0;
    endcase
  end

  // Timer registers; bus writes take priority over tick/overflow updates,
  // and the reload reads TH before any same-edge TH write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_r  <= 16'd0;
      th_r   <= 32'd0;
      tl_r   <= 32'd0;
      tcon_r <= 3'd0;
    end else begin
      if (wr_th) th_r <= wdata;

      if (state_s == T_RUN && !tick_s) pre_r <= pre_r + 16'd1;
      else                             pre_r <= 16'd0;

      if (wr_tl)       tl_r <= wdata;
      else if (ovf_s)  tl_r <= th_r;
      else if (tick_s) tl_r <= tl_r + 32'd1;

      if (wr_tcon)                            tcon_r          <= wdata[2:0];
      else if (ovf_s && tcon_r[TCON_IE])      tcon_r[TCON_ST] <= 1'b1;
    end
  end

  assign th   = th_r;
  assign tl   = tl_r;
  assign tcon = tcon_r;
  assign irq  = tcon_r[TCON_IE] & tcon_r[TCON_ST];

endmodule

// File: rtl/mmio_peripheral.sv
// MMIO responder on the data-memory port: window decode, LED/DIGI registers,
// free-running systick, combinational read mux and the timer sub-block.
module mmio_peripheral
  import mmio_peripheral_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mmio_peripheral_if.slave      bus,
  output logic                  irq,
  output logic [15:0]           led,
  output logic [3:0]            AN,
  output logic [7:0]            BCD
);

  logic        in_win_s;
  logic        wr_s;
  logic [2:0]  off_s;
  logic        unused_s;
  logic [15:0] led_r;
  logic [11:0] digi_r;
  logic [31:0] systick_r;
  logic [31:0] th_s;
  logic [31:0] tl_s;
  logic [2:0]  tcon_s;
  logic [31:0] rdata_s;

  assign in_win_s = (bus.Address[31:5] == BASE_ADDR[31:5]);
  assign wr_s     = bus.MemWrite & in_win_s;
  assign off_s    = bus.Address[4:2];
  assign unused_s = ^bus.Address[1:0];
  assign bus.hit  = (bus.MemRead | bus.MemWrite) & in_win_s;

  mmio_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_th   (wr_s && (off_s == OFF_TH)),
    .wr_tl   (wr_s && (off_s == OFF_TL)),
    .wr_tcon (wr_s && (off_s == OFF_TCON)),
    .wdata   (bus.Write_data),
    .th      (th_s),
    .tl      (tl_s),
    .tcon    (tcon_s),
    .irq     (irq)
  );

  // LED/DIGI registers and the free-running systick.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_r     <= 16'd0;
      digi_r    <= DIGI_RESET;
      systick_r <= 32'd0;
    end else begin
      systick_r <= systick_r + 32'd1;
      if (wr_s && (off_s == OFF_LED))  led_r  <= bus.Write_data[15:0];
      if (wr_s && (off_s == OFF_DIGI)) digi_r <= bus.Write_data[11:0];
    end
  end

  // Read mux: zero unless a load hits the window.
  always_comb begin
    rdata_s = 32'd0;
    if (bus.MemRead && in_win_s) begin
      case (off_s)
        OFF_TH:      rdata_s = th_s;
        OFF_TL:      rdata_s = tl_s;
        OFF_TCON:    rdata_s = {29'd0, tcon_s};
        OFF_LED:     rdata_s = {16'd0, led_r};
        OFF_DIGI:    rdata_s = {20'd0, digi_r};
        OFF_SYSTICK: rdata_s = systick_r;
        default:     rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign bus.Read_data = rdata_s;
  assign led = led_r;
  assign AN  = digi_r[11:8];
  assign BCD = digi_r[7:0];

endmodule
